bsg_buf_pipe: RTL and testbench
===============================

BSG_BUF_PIPE -- requirements
Module: bsg_buf_pipe

Interface
REQ-001 Parameter width_p, default 32: data width in bits, legal range 1 or more.
REQ-002 Parameter stages_p, default 2: number of register stages, legal range 0..8.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 Port data_i, input, width_p bits: upstream data.
REQ-006 Port v_i, input, 1 bit: upstream valid.
REQ-007 Port ready_o, output, 1 bit: block can accept data this cycle.
REQ-008 Port data_o, output, width_p bits: downstream data.
REQ-009 Port v_o, output, 1 bit: downstream valid.
REQ-010 Port ready_i, input, 1 bit: downstream accepts data this cycle.
REQ-011 Port count_o, output, $clog2(2*stages_p+1) bits (minimum 1 bit): number of words held.

Function
REQ-012 Transfer rules: an input transfer occurs when v_i and ready_o are both high; an output transfer occurs when v_o and ready_i are both high.
REQ-013 When stages_p equals 0, the block is purely combinational: data_o equals data_i, v_o equals v_i, ready_o equals ready_i, and count_o equals 0.
REQ-014 When stages_p is greater than 0, the block is a chain of stages_p two-entry stages; each stage holds 0, 1 or 2 words.
REQ-015 Stage ready is high when the stage holds fewer than 2 words; it is a registered value with no combinational path from ready_i to ready_o.
REQ-016 Stage valid is high when the stage holds 1 or more words; data_o is driven from a register, the head of the last stage.
REQ-017 Latency: into an empty pipe with ready_i held high, a word accepted in cycle t appears with v_o high in cycle t+stages_p.
REQ-018 Throughput: with v_i and ready_i held high, there is one transfer per cycle on each side, indefinitely.
REQ-019 Words emerge in acceptance order, with no loss, duplication or corruption.
REQ-020 Simultaneous enqueue and dequeue on a stage holding 1 word leaves it holding 1 word, with the new word at the head.
REQ-021 Simultaneous enqueue and dequeue on a stage holding 2 words is not possible, because ready is low; that stage dequeues only.
REQ-022 Backpressure: with ready_i low, the pipe fills to 2*stages_p words; ready_o then goes low on the cycle after the last accept.
REQ-023 Backpressure: while v_o is high and ready_i is low, data_o and v_o hold stable.
REQ-024 count_o equals the number of input transfers minus the number of output transfers since reset, updated each cycle and registered; it never exceeds 2*stages_p.
REQ-025 Input when ready_o is low is ignored; data_i and v_i are don't-care in that case.

Reset
REQ-026 While reset_i is high at a clock edge, all stages empty, and after that edge v_o is 0, ready_o is 1 and count_o is 0 (for stages_p greater than 0).
REQ-027 Reset mid-operation discards all held words; no output transfer is signalled in the cycle after reset.
REQ-028 data_o value is unspecified while v_o is 0; data registers have no reset.

Structure
REQ-029 The sub-module bsg_buf_pipe_stage (two-entry buffer, parameter width_p) is instantiated stages_p times through a generate loop.
REQ-030 The shared package bsg_buf_pipe_pkg holds the constant for maximum stages (8) and the count-width function; there are no typedefs beyond these.
REQ-031 An illegal stages_p value triggers an elaboration-time error.

Verification
REQ-032 stages_p=3, ready_i=1; single word 0xDEADBEEF accepted in cycle 10 -> v_o=1 with data_o=0xDEADBEEF in cycle 13, count_o=1 during cycles 11..13.
REQ-033 stages_p=2; stream 0..99 with v_i=1 and ready_i=1 -> 100 outputs in order, one per cycle after a 2-cycle fill, ready_o constantly 1.
REQ-034 stages_p=2, ready_i=0, v_i=1 -> 4 words accepted, ready_o=0 thereafter, count_o=4; release ready_i -> words out in order, count_o decrements by 1 per cycle.
REQ-035 stages_p=4, random v_i and ready_i at 50% for 10,000 cycles -> scoreboard matches, count_o equals the outstanding word count every cycle, data_o stable while stalled.
REQ-036 stages_p=2, 3 words held, reset_i pulsed for 1 cycle -> next cycle v_o=0, count_o=0, ready_o=1; a subsequent word passes with 2-cycle latency.
REQ-037 stages_p=0, width_p=32 -> data_o equals data_i, v_o equals v_i and ready_o equals ready_i in the same cycle for 1,000 random vectors.

Source files
------------

// File: rtl/bsg_buf_pipe_pkg.sv
// -----------------------------------------------------------------------------
// bsg_buf_pipe_pkg
// Purpose : Shared constants and helpers for the bsg_buf_pipe pipeline.
// Contents: MAX_STAGES  - largest supported number of two-entry stages.
//           count_width - bit width of the occupancy counter for a given depth.
// -----------------------------------------------------------------------------
package bsg_buf_pipe_pkg;

  localparam int MAX_STAGES = 8;

  // Width needed to hold 0 .. 2*stages; never narrower than one bit.
  function automatic int count_width(input int stages);
    if (stages <= 0) begin
      return 1;
    end else begin
      return $clog2(2 * stages + 1);
    end
  endfunction

endpackage : bsg_buf_pipe_pkg

// File: rtl/bsg_buf_pipe_stage.sv
// -----------------------------------------------------------------------------
// bsg_buf_pipe_stage
// Purpose : One two-entry elastic buffer stage. Ready and valid both come
//           straight from flops, so neither handshake direction has a
//           combinational path through the stage.
// Ports   : i_clk, i_reset        - clock, synchronous active-high reset
//           i_data, i_v, o_ready  - upstream side
//           o_data, o_v, i_ready  - downstream side (o_data is the head word)
// -----------------------------------------------------------------------------
module bsg_buf_pipe_stage #(
  parameter int width_p = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [width_p-1:0] i_data,
  input  logic               i_v,
  output logic               o_ready,
  output logic [width_p-1:0] o_data,
  output logic               o_v,
  input  logic               i_ready
);

  logic [width_p-1:0] r_head;
  logic [width_p-1:0] r_tail;
  logic [1:0]         r_cnt;
  logic               r_v;
  logic               r_ready;

  logic               w_enq;
  logic               w_deq;
  logic [1:0]         w_cnt_nxt;

  assign w_enq = i_v & r_ready;
  assign w_deq = r_v & i_ready;

  // Next occupancy from the enqueue/dequeue pair.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_enq, w_deq})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Occupancy plus pre-decoded valid/ready flops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= 2'd0;
      r_v     <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_v     <= (w_cnt_nxt != 2'd0);
      r_ready <= (w_cnt_nxt != 2'd2);
    end
  end

  // Data storage; no reset because contents are ignored while empty.
  // With one word held and a simultaneous enq/deq, the new word replaces
  // the head directly so the tail slot is never needed for pass-through.
  always_ff @(posedge i_clk) begin
    case (r_cnt)
      2'd0: begin
        if (w_enq) begin
          r_head <= i_data;
        end
      end
      2'd1: begin
        if (w_enq && w_deq) begin
          r_head <= i_data;
        end else if (w_enq) begin
          r_tail <= i_data;
        end
      end
      2'd2: begin
        if (w_deq) begin
          r_head <= r_tail;
        end
      end
      default: begin
        r_head <= r_head;
      end
    endcase
  end

  assign o_data  = r_head;
  assign o_v     = r_v;
  assign o_ready = r_ready;

endmodule : bsg_buf_pipe_stage

// File: rtl/bsg_buf_pipe.sv
// -----------------------------------------------------------------------------
// bsg_buf_pipe
// Purpose : Valid/ready pipeline of stages_p two-entry stages with a
//           registered word-count output. stages_p = 0 degenerates to wires.
// Ports   : clk_i, reset_i         - clock, synchronous active-high reset
//           data_i, v_i, ready_o   - upstream handshake
//           data_o, v_o, ready_i   - downstream handshake
//           count_o                - words currently held (0 .. 2*stages_p)
// -----------------------------------------------------------------------------
module bsg_buf_pipe
  import bsg_buf_pipe_pkg::*;
#(
  parameter int width_p  = 32,
  parameter int stages_p = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [width_p-1:0]                  data_i,
  input  logic                                v_i,
  output logic                                ready_o,
  output logic [width_p-1:0]                  data_o,
  output logic                                v_o,
  input  logic                                ready_i,
  output logic [count_width(stages_p)-1:0]    count_o
);

  localparam int CW = count_width(stages_p);

  if (stages_p < 0 || stages_p > MAX_STAGES || width_p < 1) begin : g_bad_param
    $error("bsg_buf_pipe: stages_p must be 0..%0d and width_p >= 1", MAX_STAGES);
  end

  if (stages_p == 0) begin : g_comb
    // Pure pass-through; clock and reset have no effect here.
    logic w_unused;
    assign w_unused = clk_i ^ reset_i;
    assign data_o   = data_i;
    assign v_o      = v_i;
    assign ready_o  = ready_i;
    assign count_o  = '0;
  end else begin : g_pipe
    logic [width_p-1:0] w_data [stages_p+1];
    logic [stages_p:0]  w_v;
    logic [stages_p:0]  w_ready;
    logic               w_in_x;
    logic               w_out_x;
    logic [CW-1:0]      r_count;

    assign w_data[0]         = data_i;
    assign w_v[0]            = v_i;
    assign ready_o           = w_ready[0];
    assign data_o            = w_data[stages_p];
    assign v_o               = w_v[stages_p];
    assign w_ready[stages_p] = ready_i;

    for (genvar k = 0; k < stages_p; k++) begin : g_stage
      bsg_buf_pipe_stage #(
        .width_p (width_p)
      ) u_stage (
        .i_clk   (clk_i),
        .i_reset (reset_i),
        .i_data  (w_data[k]),
        .i_v     (w_v[k]),
        .o_ready (w_ready[k]),
        .o_data  (w_data[k+1]),
        .o_v     (w_v[k+1]),
        .i_ready (w_ready[k+1])
      );
    end

    assign w_in_x  = v_i & w_ready[0];
    assign w_out_x = w_v[stages_p] & ready_i;

    // Track words held as input transfers minus output transfers.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_count <= '0;
      end else begin
        case ({w_in_x, w_out_x})
          2'b10:   r_count <= r_count + CW'(1'b1);
          2'b01:   r_count <= r_count - CW'(1'b1);
          default: r_count <= r_count;
        endcase
      end
    end

    assign count_o = r_count;
  end

endmodule : bsg_buf_pipe

// File: tb/tb_bsg_buf_pipe.sv
module tb_bsg_buf_pipe;

  localparam int S  = 3;
  localparam int W  = 32;
  localparam int CW = $clog2(2 * S + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic [W-1:0]  data_o;
  logic          v_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  logic [W-1:0]  c_data_i;
  logic          c_v_i;
  logic          c_ready_o;
  logic [W-1:0]  c_data_o;
  logic          c_v_o;
  logic          c_ready_i;
  logic [0:0]    c_count_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] model_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  bsg_buf_pipe #(.width_p(W), .stages_p(S)) u_dut (
    .clk_i   (clk),
    .reset_i (reset),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .v_o     (v_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  bsg_buf_pipe #(.width_p(W), .stages_p(0)) u_comb (
    .clk_i   (clk),
    .reset_i (reset),
    .data_i  (c_data_i),
    .v_i     (c_v_i),
    .ready_o (c_ready_o),
    .data_o  (c_data_o),
    .v_o     (c_v_o),
    .ready_i (c_ready_i),
    .count_o (c_count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (model_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    chk("drain_left", model_q.size(), 0);
  endtask

  // Scoreboard monitor: samples handshakes on the falling edge, i.e. the
  // values the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("count", count_o, model_q.size());
      if (prev_stall) begin
        chk("stall_v", v_o, 1'b1);
        chk("stall_data", data_o, prev_data);
      end
      if (v_o && ready_i) begin
        if (model_q.size() == 0) begin
          chk("spurious_out", v_o, 1'b0);
        end else begin
          chk("data", data_o, model_q.pop_front());
        end
      end
      if (v_i && ready_o) begin
        model_q.push_back(data_i);
      end
      prev_stall = v_o && !ready_i;
      prev_data  = data_o;
    end
  end

  initial begin
    int acc;
    int last_acc;
    int first_low;

    reset = 1'b1; v_i = 1'b0; ready_i = 1'b0; data_i = '0;
    c_data_i = '0; c_v_i = 1'b0; c_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_v", v_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_count", count_o, 0);
    reset = 1'b0;
    step();

    // Single-word latency.
    ready_i = 1'b1; v_i = 1'b1; data_i = 32'hDEADBEEF;
    step();
    v_i = 1'b0; data_i = $urandom;
    for (int i = 1; i <= S; i++) begin
      if (i > 1) step();
      chk("lat_v", v_o, (i == S));
      chk("lat_count", count_o, 1);
      if (i == S) chk("lat_data", data_o, 32'hDEADBEEF);
    end
    step();
    chk("lat_empty", count_o, 0);

    // Full-rate stream 0..99.
    for (int n = 0; n < 100; n++) begin
      v_i = 1'b1; data_i = n;
      chk("stream_ready", ready_o, 1'b1);
      if (n >= S) chk("stream_v", v_o, 1'b1);
      step();
    end
    v_i = 1'b0;
    wait_drain(50);

    // Backpressure fill then release.
    ready_i = 1'b0; v_i = 1'b1;
    acc = 0; last_acc = -1; first_low = -1;
    for (int i = 0; i < 6 * S + 4; i++) begin
      data_i = 200 + i;
      if (ready_o) begin
        acc++;
        last_acc = i;
      end else if (first_low < 0) begin
        first_low = i;
      end
      step();
    end
    v_i = 1'b0;
    chk("bp_accepts", acc, 2 * S);
    chk("bp_ready_low_next", first_low, last_acc + 1);
    chk("bp_ready", ready_o, 1'b0);
    chk("bp_count", count_o, 2 * S);
    ready_i = 1'b1;
    for (int i = 1; i <= 2 * S; i++) begin
      step();
      chk("bp_drain_count", count_o, 2 * S - i);
    end
    step();

    // Reset with words held.
    ready_i = 1'b0; v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 300 + i;
      step();
    end
    v_i = 1'b0;
    chk("pre_rst_count", count_o, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_v", v_o, 1'b0);
    chk("mid_rst_ready", ready_o, 1'b1);
    chk("mid_rst_count", count_o, 0);
    ready_i = 1'b1; v_i = 1'b1; data_i = 32'hCAFE0001;
    step();
    v_i = 1'b0;
    for (int i = 1; i <= S; i++) begin
      if (i > 1) step();
      chk("post_rst_v", v_o, (i == S));
      if (i == S) chk("post_rst_data", data_o, 32'hCAFE0001);
    end
    step();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      v_i     = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = $urandom;
      step();
    end
    v_i = 1'b0; ready_i = 1'b1;
    wait_drain(100);

    // Zero-stage pass-through.
    for (int i = 0; i < 1000; i++) begin
      c_data_i  = $urandom;
      c_v_i     = 1'($urandom_range(0, 1));
      c_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("comb_data", c_data_o, c_data_i);
      chk("comb_v", c_v_o, c_v_i);
      chk("comb_ready", c_ready_o, c_ready_i);
      chk("comb_count", c_count_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bsg_buf_pipe
